// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, glitch-filtered start, mid-bit sampling,
// per-word parity/framing flags, sticky overrun, valid/ack handshake plus legacy toggle.
module uart_rx_param #(
    parameter int CLK_PER_BIT = 10416,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_toggle,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int            CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    // state     | meaning
    // S_IDLE    | line idle, waiting for rxs low
    // S_START   | half-bit wait, then confirm start bit (high = glitch)
    // S_DATA    | sample data bits at bit centre, LSB first
    // S_PARITY  | sample parity bit and compare with data
    // S_STOP    | sample each stop bit, accumulate framing error
    // S_DELIVER | one cycle: publish word and flags
    // S_BREAK   | framing error seen, wait for line to return high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_BREAK
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_bitcnt, w_bitcnt_nxt;
    logic [3:0]             r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_perr, w_perr_nxt;
    logic                   r_ferr, w_ferr_nxt;
    logic                   w_rxs;
    logic                   w_bit_end;
    logic                   w_deliver;

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    assign w_bit_end = (r_bitcnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_sync   <= '1;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx};
            r_bitcnt <= w_bitcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_perr   <= w_perr_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = w_bit_end ? '0 : r_bitcnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_perr_nxt   = r_perr;
        w_ferr_nxt   = r_ferr;
        w_deliver    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_bitcnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_perr_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (r_bitcnt == HALF_CNT) begin
                    w_bitcnt_nxt = '0;
                    w_idx_nxt    = '0;
                    w_state_nxt  = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                // Shifting in at the MSB leaves the first wire bit at the LSB after DATA_BITS shifts.
                if (w_bit_end) begin
                    w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                    if (r_idx == LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_perr_nxt  = ((^r_shift) ^ w_rxs) != PAR_ODD;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_ferr_nxt = r_ferr | ~w_rxs;
                    if (r_idx == LAST_STOP) begin
                        w_state_nxt = S_DELIVER;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_DELIVER: begin
                w_deliver    = 1'b1;
                w_bitcnt_nxt = '0;
                w_state_nxt  = r_ferr ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                w_bitcnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Delivery takes priority over a same-cycle ack so a fresh word is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_toggle   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (w_deliver) begin
            rx_data    <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr;
            rx_valid   <= 1'b1;
            rx_toggle  <= ~rx_toggle;
            if (rx_valid && !rx_ack) begin
                overrun_err <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7E2 instance (3 sync stages) driven by
// directed and random frames, compared against a word-level reference model.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx8, rx7, ack8, ack7;
    logic [7:0] data8;
    logic [6:0] data7;
    logic       valid8, tog8, perr8, ferr8, ovr8;
    logic       valid7, tog7, perr7, ferr7, ovr7;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_data  [2];
    logic        exp_valid [2];
    logic        exp_tog   [2];
    logic        exp_perr  [2];
    logic        exp_ferr  [2];
    logic        exp_ovr   [2];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .rx(rx8), .rx_ack(ack8), .rx_data(data8), .rx_valid(valid8),
        .rx_toggle(tog8), .parity_err(perr8), .frame_err(ferr8), .overrun_err(ovr8));

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(3)) u_dut7 (
        .clk(clk), .rst(rst), .rx(rx7), .rx_ack(ack7), .rx_data(data7), .rx_valid(valid7),
        .rx_toggle(tog7), .parity_err(perr7), .frame_err(ferr7), .overrun_err(ovr7));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_data[s]  = '0;
            exp_valid[s] = 1'b0;
            exp_tog[s]   = 1'b0;
            exp_perr[s]  = 1'b0;
            exp_ferr[s]  = 1'b0;
            exp_ovr[s]   = 1'b0;
        end
    endtask

    task automatic model_deliver(input int sel, input logic [31:0] d, input logic pe, input logic fe);
        if (exp_valid[sel]) exp_ovr[sel] = 1'b1;
        exp_data[sel]  = d;
        exp_perr[sel]  = pe;
        exp_ferr[sel]  = fe;
        exp_valid[sel] = 1'b1;
        exp_tog[sel]   = ~exp_tog[sel];
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 1) rx7 = b;
        else          rx8 = b;
    endtask

    function automatic logic cur_tog(input int sel);
        return (sel == 1) ? tog7 : tog8;
    endfunction

    // Serialise one frame; stops holds one bit per stop slot (bit k = k-th stop bit level).
    task automatic send(input int sel, input logic [31:0] d, input logic par_flip, input logic [1:0] stops);
        int   nbits;
        int   nstop;
        int   ones;
        logic pbit;
        logic fe;
        nbits = (sel == 1) ? 7 : 8;
        nstop = (sel == 1) ? 2 : 1;
        ones  = 0;
        fe    = 1'b0;
        pbit  = 1'b0;
        drive(sel, 1'b0);
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i]);
            ones += int'(d[i]);
            tick(CPB);
        end
        if (sel == 1) begin
            pbit = logic'(ones % 2) ^ par_flip;
            drive(sel, pbit);
            tick(CPB);
        end
        for (int k = 0; k < nstop; k++) begin
            drive(sel, stops[k]);
            if (!stops[k]) fe = 1'b1;
            tick(CPB);
        end
        drive(sel, 1'b1);
        model_deliver(sel, d & ((32'd1 << nbits) - 1),
                      (sel == 1) ? (((ones + int'(pbit)) % 2) != 0) : 1'b0, fe);
    endtask

    task automatic wait_word(input int sel);
        int n;
        n = 0;
        while (cur_tog(sel) !== exp_tog[sel] && n < 4 * CPB) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_word(input int sel, input string tag);
        logic [31:0] od;
        logic        ov, ot, op, of, oo;
        if (sel == 1) begin
            od = 32'(data7); ov = valid7; ot = tog7; op = perr7; of = ferr7; oo = ovr7;
        end else begin
            od = 32'(data8); ov = valid8; ot = tog8; op = perr8; of = ferr8; oo = ovr8;
        end
        chk({tag, ".data"},    od, exp_data[sel]);
        chk({tag, ".valid"},   32'(ov), 32'(exp_valid[sel]));
        chk({tag, ".toggle"},  32'(ot), 32'(exp_tog[sel]));
        chk({tag, ".perr"},    32'(op), 32'(exp_perr[sel]));
        chk({tag, ".ferr"},    32'(of), 32'(exp_ferr[sel]));
        chk({tag, ".overrun"}, 32'(oo), 32'(exp_ovr[sel]));
    endtask

    task automatic ack(input int sel);
        if (sel == 1) ack7 = 1'b1;
        else          ack8 = 1'b1;
        tick(1);
        ack7 = 1'b0;
        ack8 = 1'b0;
        tick(1);
        exp_valid[sel] = 1'b0;
        exp_ovr[sel]   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          sel;
        logic [31:0] rd;
        logic        flip;
        logic [1:0]  st;

        rst = 1'b0; rx8 = 1'b1; rx7 = 1'b1; ack8 = 1'b0; ack7 = 1'b0;
        model_reset();
        tick(4);
        check_word(0, "reset8");
        check_word(1, "reset7");
        rst = 1'b1;
        tick(4);

        // basic 8N1 word and ack
        send(0, 32'hA5, 1'b0, 2'b11);
        wait_word(0);
        check_word(0, "t1");
        ack(0);
        check_word(0, "t1_ack");

        // short low pulse must be rejected as a glitch
        rx8 = 1'b0;
        tick(5);
        rx8 = 1'b1;
        tick(3 * CPB);
        check_word(0, "t2_glitch");
        send(0, 32'h3C, 1'b0, 2'b11);
        wait_word(0);
        check_word(0, "t2");
        ack(0);

        // even parity, 7 data bits
        send(1, 32'h55, 1'b0, 2'b11);
        wait_word(1);
        check_word(1, "t3_good");
        ack(1);
        send(1, 32'h55, 1'b1, 2'b11);
        wait_word(1);
        check_word(1, "t3_bad");
        ack(1);

        // 0x00 with low stop bit, then line held low as a break
        rx8 = 1'b0;
        tick(50 * CPB);
        model_deliver(0, 32'h00, 1'b0, 1'b1);
        check_word(0, "t4_break");
        rx8 = 1'b1;
        tick(2 * CPB);
        ack(0);
        send(0, 32'h81, 1'b0, 2'b11);
        wait_word(0);
        check_word(0, "t4_after");
        ack(0);

        // back-to-back words without ack
        send(0, 32'h11, 1'b0, 2'b11);
        send(0, 32'h22, 1'b0, 2'b11);
        wait_word(0);
        check_word(0, "t5_overrun");
        ack(0);
        check_word(0, "t5_ack");

        // reset after the third data bit of 0xF0
        drive(0, 1'b0);
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0);
            tick(CPB);
        end
        rst = 1'b0;
        tick(2);
        model_reset();
        check_word(0, "t6_rst8");
        check_word(1, "t6_rst7");
        rx8 = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2 * CPB);
        send(0, 32'h0F, 1'b0, 2'b11);
        wait_word(0);
        check_word(0, "t6");

        // random frames on both instances, occasional bad parity/stop and skipped acks
        for (int n = 0; n < 12; n++) begin
            sel  = int'($urandom_range(0, 1));
            rd   = $urandom();
            flip = logic'($urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            if (sel == 0) st[1] = 1'b1;
            send(sel, rd, (sel == 1) ? flip : 1'b0, st);
            wait_word(sel);
            check_word(sel, "rand");
            tick(2 * CPB);
            if ($urandom_range(0, 1) == 1) ack(sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
